// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: takes one op from EXU, runs a req/gnt + rvalid memory transaction,
// then holds the writeback result on a valid/ready handshake until the WBU takes it.
module ysyx_25020047_lsu #(
   parameter int unsigned RESP_TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   input  logic        in_wen,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_wen,
   output logic        misalign,
   output logic        bus_err
);
   localparam int unsigned CW = $clog2(RESP_TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StWb} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic [31:0]   data_q, data_d;
   logic [4:0]    rd_q, rd_d;
   logic          wen_q, wen_d;
   logic          mis_q, mis_d;
   logic          berr_q, berr_d;
   logic          lbu_q, lbu_d;
   logic [1:0]    lane_q, lane_d;

   logic          is_load, is_store, misal;
   logic [3:0]    strb;
   logic [31:0]   wdat;

   // Op decode; reserved encodings fall through as NONE.
   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      misal    = 1'b0;
      strb     = 4'b0000;
      wdat     = 32'h0;
      unique case (in_op)
         3'd1: begin
            is_load = 1'b1;
            misal   = (in_addr[1:0] != 2'b00);
         end
         3'd2: is_load = 1'b1;
         3'd3: begin
            is_store = 1'b1;
            misal    = (in_addr[1:0] != 2'b00);
            strb     = 4'hF;
            wdat     = in_wdata;
         end
         3'd4: begin
            is_store = 1'b1;
            strb     = 4'b0001 << in_addr[1:0];
            wdat     = {4{in_wdata[7:0]}};
         end
         3'd5: begin
            is_store = 1'b1;
            misal    = in_addr[0];
            strb     = 4'b0011 << in_addr[1:0];
            wdat     = {2{in_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign in_ready = (state_q == StIdle) && !rst;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      data_d  = data_q;
      rd_d    = rd_q;
      wen_d   = wen_q;
      mis_d   = mis_q;
      berr_d  = berr_q;
      lbu_d   = lbu_q;
      lane_d  = lane_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid && in_ready) begin
               rd_d   = in_rd;
               lbu_d  = (in_op == 3'd2);
               lane_d = in_addr[1:0];
               mis_d  = 1'b0;
               berr_d = 1'b0;
               if (!is_load && !is_store) begin
                  state_d = StWb;
                  data_d  = in_addr;
                  wen_d   = in_wen;
               end else if (misal) begin
                  state_d = StWb;
                  data_d  = 32'h0;
                  wen_d   = 1'b0;
                  mis_d   = 1'b1;
               end else begin
                  state_d = StReq;
                  addr_d  = {in_addr[31:2], 2'b00};
                  we_d    = is_store;
                  wstrb_d = strb;
                  wdata_d = wdat;
                  data_d  = 32'h0;
                  wen_d   = is_load & in_wen;
               end
            end
         end
         StReq: begin
            if (mem_gnt) begin
               state_d = StWait;
               cnt_d   = '0;
            end
         end
         StWait: begin
            cnt_d = cnt_q + CW'(1);
            // A response arriving on the last allowed cycle still counts.
            if (mem_rvalid) begin
               state_d = StWb;
               if (!we_q) begin
                  data_d = lbu_q ? {24'h0, mem_rdata[{lane_q, 3'b000} +: 8]} : mem_rdata;
               end
            end else if (cnt_q == CW'(RESP_TIMEOUT - 1)) begin
               state_d = StWb;
               berr_d  = 1'b1;
               wen_d   = 1'b0;
            end
         end
         StWb: begin
            if (out_ready) begin
               state_d = StIdle;
               mis_d   = 1'b0;
               berr_d  = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         wstrb_q <= 4'h0;
         data_q  <= 32'h0;
         rd_q    <= 5'h0;
         wen_q   <= 1'b0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
         lbu_q   <= 1'b0;
         lane_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         wen_q   <= wen_d;
         mis_q   <= mis_d;
         berr_q  <= berr_d;
         lbu_q   <= lbu_d;
         lane_q  <= lane_d;
      end
   end

   assign mem_req   = (state_q == StReq);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;
   assign out_valid = (state_q == StWb);
   assign out_data  = data_q;
   assign out_rd    = rd_q;
   assign out_wen   = wen_q;
   assign misalign  = mis_q;
   assign bus_err   = berr_q;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Randomized scoreboard bench for the LSU: stimulus pushes expected requests and writeback
// results; a memory responder and a writeback monitor pop and compare independently.
module tb_ysyx_25020047_lsu;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_wen;
   logic [2:0]  in_op;
   logic [31:0] in_addr, in_wdata;
   logic [4:0]  in_rd;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        out_valid, out_ready, out_wen, misalign, bus_err;
   logic [31:0] out_data;
   logic [4:0]  out_rd;

   ysyx_25020047_lsu #(.RESP_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_rd(in_rd), .in_wen(in_wen),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
      .out_wen(out_wen), .misalign(misalign), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        we;
   } req_t;

   typedef struct {
      int          gnt_d;
      int          rv_d;
      bit          drop;
      logic [31:0] rdata;
   } plan_t;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        wen;
      logic        mis;
      logic        berr;
      bit          chk_data;
      int          acc;
      int          lat;
   } exp_t;

   req_t  req_q[$];
   plan_t plan_q[$];
   exp_t  out_q[$];
   int    n_tests = 0;
   int    n_fail = 0;
   bit    aborting = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   task automatic fail(input string name, input string what);
      n_tests++;
      n_fail++;
      $display("FAIL %s: %s", name, what);
   endtask

   // Reference model: compute request and writeback from size/offset arithmetic, then issue.
   task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic wen, input plan_t p);
      exp_t        e;
      req_t        r;
      bit          is_ld, is_st, mis;
      int          size, off, n;
      logic [31:0] t;
      is_ld = (op == 3'd1) || (op == 3'd2);
      is_st = (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
      size  = (op == 3'd1 || op == 3'd3) ? 4 : ((op == 3'd5) ? 2 : 1);
      off   = int'(addr % 4);
      mis   = (is_ld || is_st) && (off % size != 0);
      r.addr  = addr - 32'(off);
      r.we    = is_st;
      t       = ((32'd1 << size) - 32'd1) << off;
      r.wstrb = is_st ? t[3:0] : 4'h0;
      r.wdata = (size == 4) ? wd : (size == 2) ? {2{wd[15:0]}} : {4{wd[7:0]}};
      e.rd = rd; e.mis = 1'b0; e.berr = 1'b0; e.data = 32'h0; e.chk_data = 1'b0;
      if (!is_ld && !is_st) begin
         e.data = addr; e.wen = wen; e.chk_data = 1'b1; e.lat = 1;
      end else if (mis) begin
         e.mis = 1'b1; e.wen = 1'b0; e.lat = 1;
      end else if (p.drop) begin
         e.berr = 1'b1; e.wen = 1'b0; e.lat = p.gnt_d + 2 + TO;
      end else begin
         e.lat = 3 + p.gnt_d + p.rv_d;
         if (is_ld) begin
            e.wen = wen; e.chk_data = 1'b1;
            e.data = (op == 3'd1) ? p.rdata : ((p.rdata >> (8 * off)) & 32'hFF);
         end else begin
            e.wen = 1'b0;
         end
      end
      in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd; in_rd = rd; in_wen = wen;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         fail("accept_timeout", "in_ready stayed 0 for 200 cycles, required 1");
         in_valid = 1'b0;
         return;
      end
      e.acc = cyc;
      out_q.push_back(e);
      if ((is_ld || is_st) && !mis) begin
         req_q.push_back(r);
         plan_q.push_back(p);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_op = 3'($urandom); in_addr = $urandom; in_wdata = $urandom;
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (out_q.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (out_q.size() != 0) fail("drain_timeout", "writeback results still pending");
   endtask

   initial begin : responder
      plan_t p;
      req_t  r;
      bit    ok;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      forever begin
         @(posedge clk); #1;
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         if (mem_req) begin
            if (req_q.size() == 0 || plan_q.size() == 0) begin
               fail("unexpected_mem_req", "got mem_req=1, required 0");
            end else begin
               r = req_q.pop_front();
               p = plan_q.pop_front();
               check("mem_addr", mem_addr, r.addr);
               check("mem_we", {31'h0, mem_we}, {31'h0, r.we});
               check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, r.wstrb});
               if (r.we) check("mem_wdata", mem_wdata, r.wdata);
               ok = 1'b1;
               for (int i = 0; i < p.gnt_d; i++) begin
                  // Responses before the grant must be ignored.
                  mem_rvalid = 1'($urandom_range(0, 1));
                  mem_rdata  = $urandom;
                  @(posedge clk); #1;
                  if (!mem_req) begin
                     if (!aborting) check("mem_req_held", {31'h0, mem_req}, 32'h1);
                     ok = 1'b0;
                     break;
                  end
                  check("mem_addr_held", mem_addr, r.addr);
               end
               mem_rvalid = 1'b0;
               if (ok) begin
                  mem_gnt = 1'b1;
                  @(posedge clk); #1;
                  mem_gnt = 1'b0;
                  if (!p.drop) begin
                     repeat (p.rv_d) begin
                        @(posedge clk); #1;
                     end
                     mem_rvalid = 1'b1;
                     mem_rdata  = p.rdata;
                     @(posedge clk); #1;
                     mem_rvalid = 1'b0;
                  end
               end
            end
         end
      end
   end

   initial begin : monitor
      exp_t        e;
      logic [42:0] snap, cur;
      bit          open;
      open = 1'b0; out_ready = 1'b0; snap = '0;
      forever begin
         @(posedge clk); #1;
         cur = {out_data, out_rd, out_wen, misalign, bus_err, 3'b000};
         if (out_valid) begin
            if (!open) begin
               snap = cur;
               if (out_q.size() != 0)
                  check("latency", 32'(cyc - out_q[0].acc), 32'(out_q[0].lat));
            end
            check("in_ready_busy", {31'h0, in_ready}, 32'h0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_ready) begin
               if (out_q.size() == 0) begin
                  fail("unexpected_out_valid", "got out_valid=1, required 0");
               end else begin
                  e = out_q.pop_front();
                  if (e.chk_data) check("out_data", out_data, e.data);
                  check("out_rd", {27'h0, out_rd}, {27'h0, e.rd});
                  check("out_wen", {31'h0, out_wen}, {31'h0, e.wen});
                  check("misalign", {31'h0, misalign}, {31'h0, e.mis});
                  check("bus_err", {31'h0, bus_err}, {31'h0, e.berr});
                  check("out_stable", cur[42:11], snap[42:11]);
               end
            end
            open = !out_ready;
         end else begin
            open = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin : stim
      plan_t p;
      rst = 1'b1; in_valid = 1'b0; in_op = 3'h0; in_addr = 32'h0; in_wdata = 32'h0;
      in_rd = 5'h0; in_wen = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("in_ready_in_rst", {31'h0, in_ready}, 32'h0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", {31'h0, in_ready}, 32'h1);
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_mem_ctl", {27'h0, mem_we, mem_wstrb}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_out_flags", {28'h0, out_valid, out_wen, misalign, bus_err}, 32'h0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_rd", {27'h0, out_rd}, 32'h0);

      p = '{gnt_d: 0, rv_d: 0, drop: 1'b0, rdata: 32'hAABBCCDD};
      issue(3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, p);
      issue(3'd2, 32'h8000_0003, 32'h0, 5'd7, 1'b1, p);
      issue(3'd4, 32'h8000_0002, 32'h0000_0055, 5'd8, 1'b1, p);
      issue(3'd1, 32'h8000_0002, 32'h0, 5'd9, 1'b1, p);
      p.gnt_d = 3;
      issue(3'd1, 32'h8000_0008, 32'h0, 5'd10, 1'b1, p);
      p = '{gnt_d: 0, rv_d: 0, drop: 1'b1, rdata: 32'h0};
      issue(3'd1, 32'h8000_0010, 32'h0, 5'd11, 1'b1, p);
      p = '{gnt_d: 1, rv_d: TO - 1, drop: 1'b0, rdata: 32'h1357_9BDF};
      issue(3'd1, 32'h8000_0014, 32'h0, 5'd12, 1'b1, p);

      for (int k = 0; k < 150; k++) begin
         p.gnt_d = $urandom_range(0, 3);
         p.rv_d  = $urandom_range(0, TO - 1);
         p.drop  = ($urandom_range(0, 7) == 0);
         p.rdata = $urandom;
         issue(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom), 1'($urandom), p);
      end
      drain();

      // Reset while a request is waiting for its grant.
      p = '{gnt_d: 30, rv_d: 0, drop: 1'b0, rdata: 32'h0};
      issue(3'd3, 32'h8000_0020, 32'hDEAD_BEEF, 5'd3, 1'b1, p);
      @(posedge clk); #1;
      check("req_before_rst", {31'h0, mem_req}, 32'h1);
      aborting = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_drops_req", {31'h0, mem_req}, 32'h0);
      check("rst_in_ready_low", {31'h0, in_ready}, 32'h0);
      rst = 1'b0;
      out_q.delete();
      #1;
      check("idle_after_rst", {31'h0, in_ready}, 32'h1);
      repeat (4) begin
         @(posedge clk); #1;
         check("quiet_after_rst", {30'h0, mem_req, out_valid}, 32'h0);
      end
      aborting = 1'b0;
      p = '{gnt_d: 0, rv_d: 0, drop: 1'b0, rdata: 32'h0};
      issue(3'd0, 32'hCAFE_0001, 32'h0, 5'd1, 1'b1, p);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
